// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline and memory-macro signals of the shared memory port
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic                  if_req_i;
    logic [ADDR_W-1:0]     if_addr_i;
    logic                  if_valid_o;
    logic [DATA_W-1:0]     if_rdata_o;

    logic                  dx_req_i;
    logic                  dx_we_i;
    logic                  dx_dbl_i;
    logic [ADDR_W-1:0]     dx_addr_i;
    logic [2*DATA_W-1:0]   dx_wdata_i;
    logic                  dx_done_o;
    logic [2*DATA_W-1:0]   dx_rdata_o;

    logic                  stall_fetch_o;
    logic                  x_stall_d_o;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic [DATA_W-1:0]     mem_rdata_i;

    // Arbiter side
    modport slave (
        input  if_req_i, if_addr_i, dx_req_i, dx_we_i, dx_dbl_i, dx_addr_i, dx_wdata_i,
        input  mem_rdata_i,
        output if_valid_o, if_rdata_o, dx_done_o, dx_rdata_o, stall_fetch_o, x_stall_d_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    // Pipeline / memory environment side
    modport master (
        output if_req_i, if_addr_i, dx_req_i, dx_we_i, dx_dbl_i, dx_addr_i, dx_wdata_i,
        output mem_rdata_i,
        input  if_valid_o, if_rdata_o, dx_done_o, dx_rdata_o, stall_fetch_o, x_stall_d_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch / load-store arbiter for the single-port unified memory
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BEAT1, RESP} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   lat_addr;
    logic                lat_we;
    logic                lat_dbl;
    logic [DATA_W-1:0]   lat_whi;
    logic [DATA_W-1:0]   low_reg;
    logic                if_valid_q;

    logic                fetch_grant;
    logic                data_issue;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [2*DATA_W-1:0] dx_rdata;

    assign data_issue = !rst_i && (state == IDLE) && bus.dx_req_i;

    // Data owns IDLE when it asks; fetch always owns the RESP slot so it cannot starve.
    always_comb begin
        fetch_grant = 1'b0;
        if (!rst_i && bus.if_req_i) begin
            if (state == IDLE)
                fetch_grant = !bus.dx_req_i;
            else if (state == RESP)
                fetch_grant = 1'b1;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (data_issue) begin
            mem_en    = 1'b1;
            mem_we    = bus.dx_we_i;
            mem_addr  = bus.dx_addr_i;
            mem_wdata = bus.dx_wdata_i[DATA_W-1:0];
        end else if (!rst_i && state == BEAT1) begin
            mem_en    = 1'b1;
            mem_we    = lat_we;
            mem_addr  = lat_addr + ADDR_W'(1);
            mem_wdata = lat_whi;
        end else if (fetch_grant) begin
            mem_en    = 1'b1;
            mem_addr  = bus.if_addr_i;
        end
    end

    // In RESP the macro output holds the last beat read; beat 0 of a double sits in low_reg.
    always_comb begin
        dx_rdata = '0;
        if (state == RESP && !lat_we)
            dx_rdata = lat_dbl ? {bus.mem_rdata_i, low_reg} : {{DATA_W{1'b0}}, bus.mem_rdata_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_dbl    <= 1'b0;
            lat_whi    <= '0;
            low_reg    <= '0;
            if_valid_q <= 1'b0;
        end else begin
            if_valid_q <= fetch_grant;
            case (state)
                IDLE: begin
                    if (bus.dx_req_i) begin
                        lat_addr <= bus.dx_addr_i;
                        lat_we   <= bus.dx_we_i;
                        lat_dbl  <= bus.dx_dbl_i;
                        lat_whi  <= bus.dx_wdata_i[2*DATA_W-1:DATA_W];
                        state    <= bus.dx_dbl_i ? BEAT1 : RESP;
                    end
                end
                BEAT1: begin
                    if (!lat_we)
                        low_reg <= bus.mem_rdata_i;
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.if_valid_o    = if_valid_q;
    assign bus.if_rdata_o    = bus.mem_rdata_i;
    assign bus.dx_done_o     = !rst_i && (state == RESP);
    assign bus.dx_rdata_o    = dx_rdata;
    assign bus.stall_fetch_o = !rst_i && bus.if_req_i && !fetch_grant;
    assign bus.x_stall_d_o   = !rst_i && (state == BEAT1);
    assign bus.mem_en_o      = mem_en;
    assign bus.mem_we_o      = mem_we;
    assign bus.mem_addr_o    = mem_addr;
    assign bus.mem_wdata_o   = mem_wdata;
endmodule
